// File: rtl/layer_seq_pkg.sv
// Shared state encoding and port-width helper for the layer MAC sequencer.
package layer_seq_pkg;

  typedef enum logic [1:0] {
    eIDLE  = 2'd0,
    eMAC   = 2'd1,
    eDRAIN = 2'd2,
    eFULL  = 2'd3
  } seq_state_e;

  // Address ports keep at least one bit even when the range collapses to a single entry.
  function automatic int clog2_min1(input int n);
    int w_s;
    w_s = $clog2(n);
    if (w_s < 1) begin
      return 1;
    end else begin
      return w_s;
    end
  endfunction

endpackage

// File: rtl/strobe_delay_line.sv
// Synchronously reset shift register that aligns store strobes with the MAC pipeline.
// DEPTH==0 collapses to a combinational pass-through.
module strobe_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_s;
    assign unused_s = clk_i ^ reset_i;
    assign data_o   = data_i;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift pipeline; reset flushes every stage so no stale strobe survives.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_r[i] <= {WIDTH{1'b0}};
        end
      end else begin
        stage_r[0] <= data_i;
        for (int i = 1; i < DEPTH; i++) begin
          stage_r[i] <= stage_r[i-1];
        end
      end
    end

    assign data_o = stage_r[DEPTH-1];
  end

endmodule

// File: rtl/layer_mac_sequencer.sv
// Sequences one shared MAC datapath over a fully-connected layer, neuron by neuron.
// Optional performance counters are built when LAYER_MAC_SEQ_PERF_EN is defined.
module layer_mac_sequencer
  import layer_seq_pkg::*;
#(
  parameter int INPUT_SIZE   = 16,
  parameter int LAYER_HEIGHT = 8,
  parameter int MAC_LATENCY  = 2
) (
  input  logic                                           clk_i,
  input  logic                                           reset_i,
  input  logic                                           valid_i,
  output logic                                           ready_o,
  output logic                                           load_o,
  output logic                                           mac_en_o,
  output logic                                           clear_acc_o,
  output logic [clog2_min1(INPUT_SIZE)-1:0]              in_addr_o,
  output logic [clog2_min1(INPUT_SIZE*LAYER_HEIGHT)-1:0] w_addr_o,
  output logic                                           store_o,
  output logic [clog2_min1(LAYER_HEIGHT)-1:0]            store_addr_o,
  output logic                                           valid_o,
  input  logic                                           ready_i
`ifdef LAYER_MAC_SEQ_PERF_EN
  ,
  output logic [31:0]                                    busy_cycles_o,
  output logic [15:0]                                    frames_o
`endif
);

  localparam int IN_W = clog2_min1(INPUT_SIZE);
  localparam int W_W  = clog2_min1(INPUT_SIZE*LAYER_HEIGHT);
  localparam int N_W  = clog2_min1(LAYER_HEIGHT);
  localparam int D_W  = clog2_min1(MAC_LATENCY);

  localparam logic [IN_W-1:0] IN_ZERO  = IN_W'(0);
  localparam logic [IN_W-1:0] IN_ONE   = IN_W'(1);
  localparam logic [IN_W-1:0] IN_LAST  = IN_W'(INPUT_SIZE-1);
  localparam logic [N_W-1:0]  N_ZERO   = N_W'(0);
  localparam logic [N_W-1:0]  N_ONE    = N_W'(1);
  localparam logic [N_W-1:0]  N_LAST   = N_W'(LAYER_HEIGHT-1);
  localparam logic [D_W-1:0]  D_ZERO   = D_W'(0);
  localparam logic [D_W-1:0]  D_ONE    = D_W'(1);
  localparam logic [D_W-1:0]  D_LAST   = D_W'(MAC_LATENCY-1);
  localparam logic [W_W-1:0]  W_ZERO   = W_W'(0);
  localparam logic [W_W-1:0]  W_STRIDE = W_W'(INPUT_SIZE);

  seq_state_e       state_r, state_s;
  logic [IN_W-1:0]  in_cnt_r, in_cnt_s;
  logic [N_W-1:0]   n_cnt_r, n_cnt_s;
  logic [D_W-1:0]   drain_cnt_r, drain_cnt_s;
  logic             strobe_s;
  logic [N_W:0]     dl_in_s, dl_out_s;

  // State and counter registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= eIDLE;
      in_cnt_r    <= IN_ZERO;
      n_cnt_r     <= N_ZERO;
      drain_cnt_r <= D_ZERO;
    end else begin
      state_r     <= state_s;
      in_cnt_r    <= in_cnt_s;
      n_cnt_r     <= n_cnt_s;
      drain_cnt_r <= drain_cnt_s;
    end
  end

  // Next-state, counter stepping and per-state strobes.
  always_comb begin
    state_s     = state_r;
    in_cnt_s    = in_cnt_r;
    n_cnt_s     = n_cnt_r;
    drain_cnt_s = drain_cnt_r;
    ready_o     = 1'b0;
    mac_en_o    = 1'b0;
    clear_acc_o = 1'b0;
    valid_o     = 1'b0;
    strobe_s    = 1'b0;
    case (state_r)
      eIDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          state_s  = eMAC;
          in_cnt_s = IN_ZERO;
          n_cnt_s  = N_ZERO;
        end else begin
          state_s = eIDLE;
        end
      end
      eMAC: begin
        mac_en_o    = 1'b1;
        clear_acc_o = (in_cnt_r == IN_ZERO);
        if (in_cnt_r == IN_LAST) begin
          strobe_s = 1'b1;
          in_cnt_s = IN_ZERO;
          if (n_cnt_r == N_LAST) begin
            n_cnt_s     = N_ZERO;
            drain_cnt_s = D_ZERO;
            state_s     = (MAC_LATENCY == 0) ? eFULL : eDRAIN;
          end else begin
            n_cnt_s = n_cnt_r + N_ONE;
          end
        end else begin
          in_cnt_s = in_cnt_r + IN_ONE;
        end
      end
      eDRAIN: begin
        if (drain_cnt_r == D_LAST) begin
          drain_cnt_s = D_ZERO;
          state_s     = eFULL;
        end else begin
          drain_cnt_s = drain_cnt_r + D_ONE;
        end
      end
      eFULL: begin
        valid_o = 1'b1;
        // Draining the held output and accepting the next vector share one cycle.
        ready_o = ready_i;
        if (ready_i && valid_i) begin
          state_s  = eMAC;
          in_cnt_s = IN_ZERO;
          n_cnt_s  = N_ZERO;
        end else if (ready_i) begin
          state_s = eIDLE;
        end else begin
          state_s = eFULL;
        end
      end
      default: begin
        state_s = eIDLE;
      end
    endcase
    load_o = valid_i & ready_o;
  end

  // Address generation; addresses idle at zero outside eMAC.
  always_comb begin
    if (mac_en_o) begin
      in_addr_o = in_cnt_r;
      w_addr_o  = (W_W'(n_cnt_r) * W_STRIDE) + W_W'(in_cnt_r);
    end else begin
      in_addr_o = IN_ZERO;
      w_addr_o  = W_ZERO;
    end
  end

  assign dl_in_s = {strobe_s, (strobe_s ? n_cnt_r : N_ZERO)};

  strobe_delay_line #(
    .DEPTH (MAC_LATENCY),
    .WIDTH (N_W + 1)
  ) u_store_dl (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (dl_in_s),
    .data_o  (dl_out_s)
  );

  assign store_o      = dl_out_s[N_W];
  assign store_addr_o = dl_out_s[N_W-1:0];

`ifdef LAYER_MAC_SEQ_PERF_EN
  logic [31:0] busy_r;
  logic [15:0] frames_r;

  // Saturating busy-cycle and completed-frame counters.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_r   <= 32'd0;
      frames_r <= 16'd0;
    end else begin
      if (((state_r == eMAC) || (state_r == eDRAIN)) && (busy_r != 32'hFFFF_FFFF)) begin
        busy_r <= busy_r + 32'd1;
      end
      if (valid_o && ready_i && (frames_r != 16'hFFFF)) begin
        frames_r <= frames_r + 16'd1;
      end
    end
  end

  assign busy_cycles_o = busy_r;
  assign frames_o      = frames_r;
`endif

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Directed self-checking bench: main instance (4 words x 3 neurons, latency 2) and a
// degenerate instance (1 x 1, latency 0).
module tb_layer_mac_sequencer;

  logic       clk_i;
  logic       reset_i;
  logic       valid_i, ready_i;
  logic       ready_o, load_o, mac_en_o, clear_acc_o, store_o, valid_o;
  logic [1:0] in_addr_o;
  logic [3:0] w_addr_o;
  logic [1:0] store_addr_o;

  logic       valid0_i, ready0_i;
  logic       ready0_o, load0_o, mac_en0_o, clear_acc0_o, store0_o, valid0_o;
  logic [0:0] in_addr0_o, w_addr0_o, store_addr0_o;

`ifdef LAYER_MAC_SEQ_PERF_EN
  logic [31:0] busy_cycles_o, busy_cycles0_o;
  logic [15:0] frames_o, frames0_o;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  layer_mac_sequencer #(
    .INPUT_SIZE   (4),
    .LAYER_HEIGHT (3),
    .MAC_LATENCY  (2)
  ) u_dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .load_o       (load_o),
    .mac_en_o     (mac_en_o),
    .clear_acc_o  (clear_acc_o),
    .in_addr_o    (in_addr_o),
    .w_addr_o     (w_addr_o),
    .store_o      (store_o),
    .store_addr_o (store_addr_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i)
`ifdef LAYER_MAC_SEQ_PERF_EN
    ,
    .busy_cycles_o (busy_cycles_o),
    .frames_o      (frames_o)
`endif
  );

  layer_mac_sequencer #(
    .INPUT_SIZE   (1),
    .LAYER_HEIGHT (1),
    .MAC_LATENCY  (0)
  ) u_dut0 (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .valid_i      (valid0_i),
    .ready_o      (ready0_o),
    .load_o       (load0_o),
    .mac_en_o     (mac_en0_o),
    .clear_acc_o  (clear_acc0_o),
    .in_addr_o    (in_addr0_o),
    .w_addr_o     (w_addr0_o),
    .store_o      (store0_o),
    .store_addr_o (store_addr0_o),
    .valid_o      (valid0_o),
    .ready_i      (ready0_i)
`ifdef LAYER_MAC_SEQ_PERF_EN
    ,
    .busy_cycles_o (busy_cycles0_o),
    .frames_o      (frames0_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected datapath controls c cycles after a transfer (main instance).
  task automatic frame_cyc(input string tag, input int c);
    logic mac_e, st_e;
    mac_e = (c >= 1) && (c <= 12);
    st_e  = (c == 6) || (c == 10) || (c == 14);
    chk($sformatf("%s_mac@%0d", tag, c), mac_en_o, mac_e);
    chk($sformatf("%s_clr@%0d", tag, c), clear_acc_o, mac_e && (((c - 1) % 4) == 0));
    chk($sformatf("%s_inaddr@%0d", tag, c), in_addr_o, mac_e ? ((c - 1) % 4) : 0);
    chk($sformatf("%s_waddr@%0d", tag, c), w_addr_o, mac_e ? (c - 1) : 0);
    chk($sformatf("%s_store@%0d", tag, c), store_o, st_e);
    if (st_e) chk($sformatf("%s_staddr@%0d", tag, c), store_addr_o, (c - 6) / 4);
  endtask

  // One vector, valid pulsed for a single cycle, output consumed immediately.
  task automatic plain_frame(input string tag);
    valid_i = 1'b1;
    ready_i = 1'b1;
    #1;
    chk({tag, "_ready0"}, ready_o, 1);
    chk({tag, "_load0"}, load_o, 1);
    for (int c = 1; c <= 16; c++) begin
      step();
      valid_i = 1'b0;
      #1;
      frame_cyc(tag, c);
      chk($sformatf("%s_valid@%0d", tag, c), valid_o, c == 15);
      chk($sformatf("%s_ready@%0d", tag, c), ready_o, c >= 15);
    end
  endtask

  initial begin
    reset_i  = 1'b1;
    valid_i  = 1'b0;
    ready_i  = 1'b0;
    valid0_i = 1'b0;
    ready0_i = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_mac", mac_en_o, 0);
    chk("rst_clr", clear_acc_o, 0);
    chk("rst_store", store_o, 0);
    chk("rst_load", load_o, 0);
    chk("rst_inaddr", in_addr_o, 0);
    chk("rst_waddr", w_addr_o, 0);
    chk("rst_staddr", store_addr_o, 0);
    chk("rst_ready0", ready0_o, 1);
    reset_i = 1'b0;

    // Degenerate 1x1 layer with zero MAC latency
    valid0_i = 1'b1;
    ready0_i = 1'b1;
    #1;
    chk("s5_load", load0_o, 1);
    step();
    valid0_i = 1'b0;
    #1;
    chk("s5_mac", mac_en0_o, 1);
    chk("s5_clr", clear_acc0_o, 1);
    chk("s5_store", store0_o, 1);
    chk("s5_staddr", store_addr0_o, 0);
    chk("s5_valid1", valid0_o, 0);
    chk("s5_ready1", ready0_o, 0);
    step();
    chk("s5_valid2", valid0_o, 1);
    chk("s5_mac2", mac_en0_o, 0);
    chk("s5_store2", store0_o, 0);
    step();
    chk("s5_valid3", valid0_o, 0);
    chk("s5_ready3", ready0_o, 1);

    // Single vector; valid dropped during eMAC
    plain_frame("s1");

    // Back-pressure until cycle 20 with a second and third vector queued
    valid_i = 1'b1;
    ready_i = 1'b0;
    #1;
    chk("s2_load0", load_o, 1);
    for (int r = 1; r <= 36; r++) begin
      step();
      valid_i = (r <= 20);
      ready_i = (r >= 20);
      #1;
      frame_cyc("s2", (r <= 20) ? r : (r - 20));
      chk($sformatf("s2_valid@%0d", r), valid_o, ((r >= 15) && (r <= 20)) || (r == 35));
      chk($sformatf("s2_ready@%0d", r), ready_o, (r == 20) || (r >= 35));
      chk($sformatf("s2_load@%0d", r), load_o, r == 20);
`ifdef LAYER_MAC_SEQ_PERF_EN
      if (r == 21) begin
        chk("s6_busy", busy_cycles_o, 28);
        chk("s6_frames", frames_o, 2);
      end
`endif
    end

    // Reset mid-eMAC: no leftover stores, clean restart afterwards
    valid_i = 1'b1;
    ready_i = 1'b1;
    #1;
    chk("s3_load0", load_o, 1);
    for (int c = 1; c <= 16; c++) begin
      step();
      valid_i = 1'b0;
      reset_i = (c == 7);
      #1;
      if (c <= 7) begin
        frame_cyc("s3", c);
      end else begin
        chk($sformatf("s3_mac@%0d", c), mac_en_o, 0);
        chk($sformatf("s3_store@%0d", c), store_o, 0);
        chk($sformatf("s3_ready@%0d", c), ready_o, 1);
        chk($sformatf("s3_valid@%0d", c), valid_o, 0);
        chk($sformatf("s3_waddr@%0d", c), w_addr_o, 0);
      end
`ifdef LAYER_MAC_SEQ_PERF_EN
      if (c == 8) begin
        chk("s3_busy", busy_cycles_o, 0);
        chk("s3_frames", frames_o, 0);
      end
`endif
    end
    plain_frame("s3b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
